// File: rtl/axi_ram_rd.sv
// AXI4 read-only slave backed by a synchronous RAM, with a backdoor write port for preload.
// Serves one burst at a time (FIXED/INCR/WRAP) and honours R-channel backpressure.
`timescale 1ns/1ps
module axi_ram_rd #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 10,
  parameter int MEM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ID_WIDTH-1:0]       s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  input  logic                      s_axi_arlock,
  input  logic [3:0]                s_axi_arqos,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [ID_WIDTH-1:0]       s_axi_rid,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  input  logic                      mem_wr_en,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_wr_addr,
  input  logic [DATA_WIDTH-1:0]     mem_wr_data
);

  localparam int LSB   = $clog2(DATA_WIDTH / 8);
  localparam int DEPTH = 2 ** (MEM_ADDR_WIDTH - LSB);
  localparam logic [2:0] MAX_SIZE = 3'(LSB);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [7:0]              cnt;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   incr;
  logic [ADDR_WIDTH-1:0]   wrap_mask;
  logic                    is_wrap;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [2:0]              rd_size;
  logic                    rd_oor;
  logic [1:0]              rd_resp;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    load_next;
  logic                    unused_ok;

  // Address of the beat after the one currently held in the output register.
  always_comb begin
    incr      = ADDR_WIDTH'(1) << size_q;
    wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    is_wrap   = (burst_q == 2'b10) &&
                (len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15);
    if (burst_q == 2'b00)
      next_addr = addr_q;
    else if (is_wrap)
      next_addr = (addr_q & ~wrap_mask) | ((addr_q + incr) & wrap_mask);
    else
      next_addr = addr_q + incr;
  end

  // The first beat reads straight from the AR channel; later beats from the generator.
  assign rd_addr   = (state == IDLE) ? s_axi_araddr : next_addr;
  assign rd_size   = (state == IDLE) ? s_axi_arsize : size_q;
  assign rd_oor    = (rd_addr >> MEM_ADDR_WIDTH) != '0;
  assign rd_resp   = (rd_oor || (rd_size > MAX_SIZE)) ? 2'b10 : 2'b00;
  assign rd_word   = mem[rd_addr[MEM_ADDR_WIDTH-1:LSB]];
  assign rd_data   = rd_oor ? '0 : rd_word;
  assign load_next = (state == BURST) && (!s_axi_rvalid || s_axi_rready) && (cnt != len_q);

  assign unused_ok = ^{s_axi_arlock, s_axi_arqos, mem_wr_addr};

  always_ff @(posedge clk) begin
    if (mem_wr_en)
      mem[mem_wr_addr[MEM_ADDR_WIDTH-1:LSB]] <= mem_wr_data;
  end

  // The R output register doubles as the RAM read register, so a read issued in
  // one cycle is visible as a valid beat in the next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= 2'b00;
      addr_q        <= '0;
      len_q         <= '0;
      cnt           <= '0;
      size_q        <= '0;
      burst_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_axi_arready && s_axi_arvalid) begin
            s_axi_arready <= 1'b0;
            s_axi_rid     <= s_axi_arid;
            len_q         <= s_axi_arlen;
            size_q        <= s_axi_arsize;
            burst_q       <= s_axi_arburst;
            addr_q        <= rd_addr;
            cnt           <= 8'd0;
            s_axi_rvalid  <= 1'b1;
            s_axi_rlast   <= (s_axi_arlen == 8'd0);
            s_axi_rdata   <= rd_data;
            s_axi_rresp   <= rd_resp;
            state         <= BURST;
          end else begin
            s_axi_arready <= 1'b1;
          end
        end
        BURST: begin
          if (s_axi_rvalid && s_axi_rready && s_axi_rlast) begin
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_arready <= 1'b1;
            state         <= IDLE;
          end else if (load_next) begin
            addr_q       <= rd_addr;
            cnt          <= cnt + 8'd1;
            s_axi_rvalid <= 1'b1;
            s_axi_rlast  <= ((cnt + 8'd1) == len_q);
            s_axi_rdata  <= rd_data;
            s_axi_rresp  <= rd_resp;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ram_rd.sv
// Self-checking bench for axi_ram_rd: table vectors, random bursts against a closed-form
// address/data model, and hand sequences for back-to-back AR, same-cycle write and reset.
`timescale 1ns/1ps
module tb_axi_ram_rd;

  localparam int WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  s_axi_arid;
  logic [31:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arlock;
  logic [3:0]  s_axi_arqos;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [9:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic        mem_wr_en;
  logic [11:0] mem_wr_addr;
  logic [31:0] mem_wr_data;

  always #5 clk = ~clk;

  axi_ram_rd #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .ID_WIDTH(10), .MEM_ADDR_WIDTH(12)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arqos(s_axi_arqos), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  int assertions = 0;
  int failures   = 0;

  logic [31:0] model_mem [WORDS];
  logic [31:0] got_data [$];
  logic [1:0]  got_resp [$];
  logic        got_last [$];
  logic [9:0]  got_id   [$];

  typedef struct {
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [9:0]       id;
    int               mode;
    logic [3:0][31:0] exp_data;
    logic [3:0][1:0]  exp_resp;
  } vec_t;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                                 input logic [1:0] b, input logic [9:0] id, input int m,
                                 input logic [31:0] d0, input logic [31:0] d1,
                                 input logic [31:0] d2, input logic [31:0] d3,
                                 input logic [1:0] r0, input logic [1:0] r1,
                                 input logic [1:0] r2, input logic [1:0] r3);
    vec_t v;
    v.addr = a; v.len = l; v.size = s; v.burst = b; v.id = id; v.mode = m;
    v.exp_data[0] = d0; v.exp_data[1] = d1; v.exp_data[2] = d2; v.exp_data[3] = d3;
    v.exp_resp[0] = r0; v.exp_resp[1] = r1; v.exp_resp[2] = r2; v.exp_resp[3] = r3;
    return v;
  endfunction

  // Byte address of beat i, computed in closed form rather than beat-by-beat.
  function automatic logic [31:0] modelAddr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst,
                                            input int i);
    logic [31:0] incr, step, wrap, base;
    incr = 32'd1 << size;
    step = 32'(i) * incr;
    if (burst == 2'b00) return a;
    if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      wrap = (32'(len) + 32'd1) * incr;
      base = a - (a % wrap);
      return base + (((a - base) + step) % wrap);
    end
    return a + step;
  endfunction

  task automatic writeWord(input logic [11:0] a, input logic [31:0] d);
    mem_wr_en = 1'b1; mem_wr_addr = a; mem_wr_data = d;
    model_mem[a[11:2]] = d;
    @(negedge clk);
    mem_wr_en = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                               input logic [1:0] b, input logic [9:0] id, output logic ok);
    ok = 1'b0;
    s_axi_arvalid = 1'b1; s_axi_araddr = a; s_axi_arlen = l; s_axi_arsize = s;
    s_axi_arburst = b; s_axi_arid = id; s_axi_arqos = 4'($urandom);
    for (int k = 0; k < 50; k++) begin
      if (s_axi_arready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(negedge clk);
    s_axi_arvalid = 1'b0;
    checkOutput("ar_accept", ok, 1);
    if (ok) begin
      checkOutput("first_beat_rvalid", s_axi_rvalid, 1);
      checkOutput("arready_drop", s_axi_arready, 0);
    end
  endtask

  // mode 0: rready high; mode 1: pattern 1,0,0 repeating; mode 2: random.
  task automatic collectBurst(input int mode, output int nbeats, output int ncycles,
                              output logic timeout);
    logic        stalled = 1'b0;
    logic        done    = 1'b0;
    logic        rr;
    logic [45:0] held    = '0;
    int          k       = 0;
    nbeats = 0;
    while (!done && k < 200) begin
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 3 == 0) : 1'($urandom);
      s_axi_rready = rr;
      if (stalled)
        checkOutput("stall_stable", {s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid}, held);
      if (s_axi_rvalid && rr) begin
        got_data.push_back(s_axi_rdata);
        got_resp.push_back(s_axi_rresp);
        got_last.push_back(s_axi_rlast);
        got_id.push_back(s_axi_rid);
        nbeats++;
        if (s_axi_rlast) done = 1'b1;
      end
      stalled = s_axi_rvalid && !rr;
      held    = {s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid};
      @(negedge clk);
      k++;
    end
    s_axi_rready = 1'b0;
    ncycles = k;
    timeout = !done;
  endtask

  task automatic runBurst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic [9:0] id, input int mode);
    logic        ok, to;
    int          nb, nc;
    logic [31:0] ba;
    logic        oor;
    got_data.delete(); got_resp.delete(); got_last.delete(); got_id.delete();
    applyStimulus(a, l, s, b, id, ok);
    if (!ok) return;
    collectBurst(mode, nb, nc, to);
    checkOutput("burst_done", to, 0);
    checkOutput("beat_count", nb, l + 1);
    if (mode == 0) checkOutput("throughput_cycles", nc, l + 1);
    for (int i = 0; i < nb && i <= int'(l); i++) begin
      ba  = modelAddr(a, l, s, b, i);
      oor = (ba >= 32'h1000);
      checkOutput($sformatf("rdata[%0d]@%0h", i, ba), got_data[i], oor ? 32'h0 : model_mem[ba[11:2]]);
      checkOutput($sformatf("rresp[%0d]", i), got_resp[i], (oor || s > 3'd2) ? 2'b10 : 2'b00);
      checkOutput($sformatf("rlast[%0d]", i), got_last[i], (i == int'(l)));
      checkOutput($sformatf("rid[%0d]", i), got_id[i], id);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[8];
    logic ok;

    rst = 1'b0; s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arlock = 1'b0; s_axi_arqos = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset_arready", s_axi_arready, 0);
    checkOutput("reset_rvalid", s_axi_rvalid, 0);
    checkOutput("reset_rlast", s_axi_rlast, 0);
    checkOutput("reset_rid", s_axi_rid, 0);
    checkOutput("reset_rdata", s_axi_rdata, 0);
    checkOutput("reset_rresp", s_axi_rresp, 0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("arready_after_reset", s_axi_arready, 1);

    for (int i = 0; i < WORDS; i++) writeWord(12'(i * 4), $urandom);
    for (int i = 0; i < 16; i++) writeWord(12'(i * 4), 32'hA0 + 32'(i));
    writeWord(12'hFF8, 32'hB0FE);
    writeWord(12'hFFC, 32'hB0FF);

    vecs[0] = mkVec(32'h10,  3, 2, 2'b01, 10'h155, 0, 32'hA4, 32'hA5, 32'hA6, 32'hA7, 0, 0, 0, 0);
    vecs[1] = mkVec(32'h38,  3, 2, 2'b10, 10'h0AA, 0, 32'hAE, 32'hAF, 32'hAC, 32'hAD, 0, 0, 0, 0);
    vecs[2] = mkVec(32'h08,  2, 2, 2'b00, 10'h003, 1, 32'hA2, 32'hA2, 32'hA2, 32'h0,  0, 0, 0, 0);
    vecs[3] = mkVec(32'hFF8, 3, 2, 2'b01, 10'h201, 0, 32'hB0FE, 32'hB0FF, 32'h0, 32'h0, 0, 0, 2, 2);
    vecs[4] = mkVec(32'h04,  1, 3, 2'b01, 10'h007, 0, 32'hA1, 32'hA3, 32'h0, 32'h0, 2, 2, 0, 0);
    vecs[5] = mkVec(32'h00,  1, 2, 2'b11, 10'h3FF, 2, 32'hA0, 32'hA1, 32'h0, 32'h0, 0, 0, 0, 0);
    vecs[6] = mkVec(32'h34,  2, 2, 2'b10, 10'h010, 0, 32'hAD, 32'hAE, 32'hAF, 32'h0, 0, 0, 0, 0);
    vecs[7] = mkVec(32'h11,  3, 0, 2'b01, 10'h020, 1, 32'hA4, 32'hA4, 32'hA4, 32'hA5, 0, 0, 0, 0);

    for (int v = 0; v < 8; v++) begin
      runBurst(vecs[v].addr, vecs[v].len, vecs[v].size, vecs[v].burst, vecs[v].id, vecs[v].mode);
      for (int i = 0; i <= int'(vecs[v].len) && i < 4 && i < got_data.size(); i++) begin
        checkOutput($sformatf("tbl%0d_rdata[%0d]", v, i), got_data[i], vecs[v].exp_data[i]);
        checkOutput($sformatf("tbl%0d_rresp[%0d]", v, i), got_resp[i], vecs[v].exp_resp[i]);
      end
    end

    for (int t = 0; t < 30; t++) begin
      logic [31:0] a;
      logic [2:0]  s;
      a = ($urandom % 8 == 0) ? $urandom : 32'($urandom_range(0, 32'h1100));
      s = ($urandom % 6 == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom % 3);
      runBurst(a, 8'($urandom % 16), s, 2'($urandom), 10'($urandom), $urandom % 3);
    end

    // Backdoor write and AR read of the same word on the same edge must return old data.
    checkOutput("rw_arready_idle", s_axi_arready, 1);
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h20; s_axi_arlen = 8'd0; s_axi_arsize = 3'd2;
    s_axi_arburst = 2'b01; s_axi_arid = 10'h011;
    mem_wr_en = 1'b1; mem_wr_addr = 12'h020; mem_wr_data = 32'h1234_5678;
    @(negedge clk);
    mem_wr_en = 1'b0; s_axi_arvalid = 1'b0;
    model_mem[8] = 32'h1234_5678;
    checkOutput("rw_same_cycle_rvalid", s_axi_rvalid, 1);
    checkOutput("rw_same_cycle_old", s_axi_rdata, 32'hA8);
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
    runBurst(32'h20, 0, 2, 2'b01, 10'h012, 0);

    // Two len=0 bursts with arvalid held high throughout.
    checkOutput("b2b_arready_idle", s_axi_arready, 1);
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h14; s_axi_arlen = 8'd0; s_axi_arsize = 3'd2;
    s_axi_arburst = 2'b01; s_axi_arid = 10'h101;
    @(negedge clk);
    checkOutput("b2b_first_rvalid", s_axi_rvalid, 1);
    checkOutput("b2b_first_rdata", s_axi_rdata, 32'hA5);
    checkOutput("b2b_first_rlast", s_axi_rlast, 1);
    checkOutput("b2b_arready_busy", s_axi_arready, 0);
    s_axi_araddr = 32'h18; s_axi_arid = 10'h102;
    @(negedge clk);
    checkOutput("b2b_arready_pending", s_axi_arready, 0);
    checkOutput("b2b_rvalid_pending", s_axi_rvalid, 1);
    s_axi_rready = 1'b1;
    @(negedge clk);
    checkOutput("b2b_arready_reopen", s_axi_arready, 1);
    checkOutput("b2b_rvalid_gap", s_axi_rvalid, 0);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    checkOutput("b2b_second_rvalid", s_axi_rvalid, 1);
    checkOutput("b2b_second_rdata", s_axi_rdata, 32'hA6);
    checkOutput("b2b_second_rid", s_axi_rid, 10'h102);
    checkOutput("b2b_second_arready", s_axi_arready, 0);
    @(negedge clk);
    checkOutput("b2b_second_done", s_axi_rvalid, 0);
    s_axi_rready = 1'b0;

    // Asynchronous reset while beat 2 of a len=7 burst is on the bus.
    s_axi_rready = 1'b1;
    applyStimulus(32'h0, 7, 2, 2'b01, 10'h01F, ok);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_pre_beat2", s_axi_rdata, 32'hA2);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_async_rvalid", s_axi_rvalid, 0);
    checkOutput("rst_async_arready", s_axi_arready, 0);
    checkOutput("rst_async_rlast", s_axi_rlast, 0);
    checkOutput("rst_async_rdata", s_axi_rdata, 0);
    s_axi_rready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_release_arready", s_axi_arready, 1);
    checkOutput("rst_release_rvalid", s_axi_rvalid, 0);
    runBurst(32'h3C, 1, 2, 2'b01, 10'h02A, 0);
    runBurst(32'h10, 3, 2, 2'b01, 10'h155, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
